// File: rtl/dac_spi_salida.sv
// DAC output stage: rounds/saturates a signed Q-format filter sample to a 12-bit
// offset-binary code and shifts it out as a 16-bit SPI frame, with a one-deep pending buffer.
module dac_spi_salida #(
    parameter int Width     = 22,
    parameter int Presicion = 14,
    parameter int Magnitud  = Width - Presicion - 1,
    parameter int DIV       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic signed [Width-1:0] yk,
    output logic                    dac_sync_n,
    output logic                    dac_sclk,
    output logic                    dac_din,
    output logic                    busy,
    output logic                    sat,
    output logic                    overrun
);

    // One guard bit above the sample so rounding the most positive input cannot wrap.
    localparam int ExtW  = Magnitud + Presicion + 2;
    localparam int Shift = Presicion - 11;
    localparam int CntW  = $clog2(2 * DIV) + 1;
    localparam logic signed [ExtW-1:0] RoundK = {{(ExtW-1){1'b0}}, 1'b1} << (Presicion - 12);
    localparam logic signed [ExtW-1:0] Offset = ExtW'(32'd2048);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                  state_r, state_n;
    logic [CntW-1:0]         cnt_r, cnt_n;
    logic [3:0]              bit_r, bit_n;
    logic                    phase_r, phase_n;
    logic signed [Width-1:0] sample_r, sample_n;
    logic signed [Width-1:0] pend_r, pend_n;
    logic                    pend_full_r, pend_full_n;
    logic [15:0]             frame_r, frame_n;
    logic                    sync_n_r, sync_n_n;
    logic                    sclk_r, sclk_n;
    logic                    din_r, din_n;
    logic                    sat_r, sat_n;
    logic                    overrun_r, overrun_n;
    logic                    busy_r;

    logic signed [ExtW-1:0]  ext_s, rnd_s, code_full_s;
    logic [11:0]             code_s;
    logic                    sat_s;
    logic [15:0]             frame_s;
    logic                    gap_exit_s;
    logic                    pend_write_s;

    // Round-to-nearest, offset to unsigned, then clamp into the 12-bit code range.
    always_comb begin
        ext_s       = ExtW'(sample_r);
        rnd_s       = (ext_s + RoundK) >>> Shift;
        code_full_s = rnd_s + Offset;
        code_s      = 12'd0;
        sat_s       = 1'b0;
        if (code_full_s[ExtW-1]) begin
            code_s = 12'd0;
            sat_s  = 1'b1;
        end else if (|code_full_s[ExtW-2:12]) begin
            code_s = 12'hFFF;
            sat_s  = 1'b1;
        end else begin
            code_s = code_full_s[11:0];
            sat_s  = 1'b0;
        end
        frame_s = {4'b0000, code_s};
    end

    assign gap_exit_s   = (state_r == GAP) && (cnt_r == CntW'(2 * DIV - 1));
    assign pend_write_s = sample_tick && (state_r != IDLE) && !gap_exit_s;

    // Next-state and next-output logic for the frame sequencer and pending buffer.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        bit_n       = bit_r;
        phase_n     = phase_r;
        sample_n    = sample_r;
        pend_n      = pend_r;
        pend_full_n = pend_full_r;
        frame_n     = frame_r;
        sync_n_n    = sync_n_r;
        sclk_n      = sclk_r;
        din_n       = din_r;
        sat_n       = sat_r;
        overrun_n   = 1'b0;
        case (state_r)
            IDLE: begin
                sync_n_n = 1'b1;
                sclk_n   = 1'b1;
                if (sample_tick) begin
                    sample_n = yk;
                    state_n  = LOAD;
                end else begin
                    state_n  = IDLE;
                end
            end
            LOAD: begin
                frame_n  = frame_s;
                sat_n    = sat_s;
                bit_n    = 4'd15;
                cnt_n    = '0;
                phase_n  = 1'b0;
                sync_n_n = 1'b0;
                sclk_n   = 1'b1;
                din_n    = frame_s[15];
                state_n  = SHIFT;
            end
            SHIFT: begin
                if (cnt_r == CntW'(DIV - 1)) begin
                    cnt_n = '0;
                    if (!phase_r) begin
                        phase_n = 1'b1;
                        sclk_n  = 1'b0;
                    end else if (bit_r == 4'd0) begin
                        phase_n  = 1'b0;
                        sclk_n   = 1'b1;
                        sync_n_n = 1'b1;
                        din_n    = 1'b0;
                        state_n  = GAP;
                    end else begin
                        phase_n = 1'b0;
                        sclk_n  = 1'b1;
                        bit_n   = bit_r - 4'd1;
                        din_n   = frame_r[bit_r - 4'd1];
                    end
                end else begin
                    cnt_n = cnt_r + CntW'(1);
                end
            end
            GAP: begin
                if (gap_exit_s) begin
                    cnt_n = '0;
                    // A tick landing on the exit cycle is kept rather than stranded in IDLE.
                    if (pend_full_r) begin
                        sample_n    = pend_r;
                        state_n     = LOAD;
                        pend_full_n = sample_tick;
                        pend_n      = sample_tick ? yk : pend_r;
                    end else if (sample_tick) begin
                        sample_n = yk;
                        state_n  = LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_r + CntW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (pend_write_s) begin
            pend_n      = yk;
            pend_full_n = 1'b1;
            overrun_n   = pend_full_r;
        end else begin
            overrun_n = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame and drops the pending sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            bit_r       <= 4'd0;
            phase_r     <= 1'b0;
            sample_r    <= '0;
            pend_r      <= '0;
            pend_full_r <= 1'b0;
            frame_r     <= 16'd0;
            sync_n_r    <= 1'b1;
            sclk_r      <= 1'b1;
            din_r       <= 1'b0;
            sat_r       <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            bit_r       <= bit_n;
            phase_r     <= phase_n;
            sample_r    <= sample_n;
            pend_r      <= pend_n;
            pend_full_r <= pend_full_n;
            frame_r     <= frame_n;
            sync_n_r    <= sync_n_n;
            sclk_r      <= sclk_n;
            din_r       <= din_n;
            sat_r       <= sat_n;
            overrun_r   <= overrun_n;
            busy_r      <= (state_n != IDLE);
        end
    end

    assign dac_sync_n = sync_n_r;
    assign dac_sclk   = sclk_r;
    assign dac_din    = din_r;
    assign busy       = busy_r;
    assign sat        = sat_r;
    assign overrun    = overrun_r;

endmodule
